// File: rtl/simd_dp_mac_pipe_if.sv
// ---------------------------------------------------------------------------
// simd_dp_mac_pipe_if
//   Bundles the operand stream and the result stream of the SIMD dot-product
//   accumulator.
//
//   Handshake: both streams use valid/ready. A transfer happens on the rising
//   clk edge where valid && ready are both high. A producer that raises valid
//   keeps valid and its payload stable until that edge. Ready may depend on
//   the consumer's state, but valid never depends on ready.
//
//   Signals
//     in_valid / in_ready   operand beat handshake
//     in_mode               lane precision of this beat (00 int2 .. 11 int16)
//     in_a / in_b           packed unsigned operands, lane 0 at the LSBs
//     in_last               beat closes the current frame
//     out_valid / out_ready frame result handshake
//     out_acc               frame dot-product sum
//     out_count             beats in the frame (wraps mod 2^CNT_W)
//     out_sat               accumulator saturated during the frame
//
//   Modports
//     master  operand streamer / result consumer side (drives inputs)
//     slave   accumulator side (simd_dp_mac_pipe)
// ---------------------------------------------------------------------------
interface simd_dp_mac_pipe_if #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport master (
        output in_valid, in_mode, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_sat
    );
endinterface

// File: rtl/simd_dp_mac_pipe.sv
// ---------------------------------------------------------------------------
// simd_dp_mac_pipe
//   Pipelined, precision-selectable SIMD dot-product accumulator. Each
//   accepted beat multiplies the packed unsigned operands lane-wise in the
//   beat's own precision and reduces the lanes to one beat sum. Beat sums
//   accumulate over a frame closed by in_last; one result per frame is
//   presented on the out_* valid/ready stream.
//
//   Pipeline
//     S1  lane products (packed per mode) + valid/last/mode tags
//     S2  beat sum, zero-extended to ACC_W
//     S3  frame accumulator, beat counter and result registers
//   A last beat accepted in cycle N shows out_valid in cycle N+3.
//
//   Ports
//     clk    rising-edge clock
//     nrst   asynchronous active-low reset
//     bus    simd_dp_mac_pipe_if.slave (operand and result streams)
//
//   Configuration macro
//     SIMD_DP_SAT_EN  defined: accumulator clamps at 2^ACC_W-1 and a sticky
//                     per-frame flag is reported on out_sat.
//                     undefined: accumulator wraps mod 2^ACC_W, out_sat = 0.
// ---------------------------------------------------------------------------
module simd_dp_mac_pipe #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    simd_dp_mac_pipe_if.slave bus
);
    // Every mode's lane products pack into exactly 2*WIDTH bits.
    localparam int PW = 2 * WIDTH;

    logic             stall;

    logic             s1_valid_q, s1_valid_d;
    logic             s1_last_q,  s1_last_d;
    logic [1:0]       s1_mode_q,  s1_mode_d;
    logic [PW-1:0]    s1_prod_q,  s1_prod_d;
    logic [PW-1:0]    prod_c;

    logic             s2_valid_q, s2_valid_d;
    logic             s2_last_q,  s2_last_d;
    logic [ACC_W-1:0] s2_sum_q,   s2_sum_d;
    logic [ACC_W-1:0] sum_c;

    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_acc_q,   out_acc_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [ACC_W-1:0] total;

`ifdef SIMD_DP_SAT_EN
    logic             sat_q,     sat_d;
    logic             out_sat_q, out_sat_d;
    logic [ACC_W:0]   sum_ext;
    logic             ovf;

    assign sum_ext = {1'b0, acc_q} + {1'b0, s2_sum_q};
    assign ovf     = sum_ext[ACC_W];
    assign total   = ovf ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign total   = acc_q + s2_sum_q;
`endif

    // A result that is offered but not taken freezes the whole pipe.
    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_count = out_count_q;
`ifdef SIMD_DP_SAT_EN
    assign bus.out_sat   = out_sat_q;
`else
    assign bus.out_sat   = 1'b0;
`endif

    // Lane products of the incoming beat; lane i of a w-bit mode sits at
    // bits [2w*i +: 2w].
    always_comb begin
        prod_c = '0;
        case (bus.in_mode)
            2'b00: for (int i = 0; i < WIDTH / 2; i++)
                prod_c[4*i +: 4] = 4'(bus.in_a[2*i +: 2]) * 4'(bus.in_b[2*i +: 2]);
            2'b01: for (int i = 0; i < WIDTH / 4; i++)
                prod_c[8*i +: 8] = 8'(bus.in_a[4*i +: 4]) * 8'(bus.in_b[4*i +: 4]);
            2'b10: for (int i = 0; i < WIDTH / 8; i++)
                prod_c[16*i +: 16] = 16'(bus.in_a[8*i +: 8]) * 16'(bus.in_b[8*i +: 8]);
            default: for (int i = 0; i < WIDTH / 16; i++)
                prod_c[32*i +: 32] = 32'(bus.in_a[16*i +: 16]) * 32'(bus.in_b[16*i +: 16]);
        endcase
    end

    // Lane reduction of the S1 products using the mode tag carried with them.
    always_comb begin
        sum_c = '0;
        case (s1_mode_q)
            2'b00: for (int i = 0; i < WIDTH / 2; i++)
                sum_c = sum_c + ACC_W'(s1_prod_q[4*i +: 4]);
            2'b01: for (int i = 0; i < WIDTH / 4; i++)
                sum_c = sum_c + ACC_W'(s1_prod_q[8*i +: 8]);
            2'b10: for (int i = 0; i < WIDTH / 8; i++)
                sum_c = sum_c + ACC_W'(s1_prod_q[16*i +: 16]);
            default: for (int i = 0; i < WIDTH / 16; i++)
                sum_c = sum_c + ACC_W'(s1_prod_q[32*i +: 32]);
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_mode_d   = s1_mode_q;
        s1_prod_d   = s1_prod_q;
        s2_valid_d  = s2_valid_q;
        s2_last_d   = s2_last_q;
        s2_sum_d    = s2_sum_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
`ifdef SIMD_DP_SAT_EN
        sat_d       = sat_q;
        out_sat_d   = out_sat_q;
`endif
        if (!stall) begin
            s1_valid_d = bus.in_valid;
            s1_last_d  = bus.in_last;
            s1_mode_d  = bus.in_mode;
            s1_prod_d  = prod_c;

            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_sum_d   = sum_c;

            // Either nothing was offered or the offered result was taken
            // this cycle; a closing beat reloads it below.
            out_valid_d = 1'b0;
            if (s2_valid_q) begin
                if (s2_last_q) begin
                    out_acc_d   = total;
                    out_count_d = cnt_q + CNT_W'(1);
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
`ifdef SIMD_DP_SAT_EN
                    out_sat_d   = sat_q | ovf;
                    sat_d       = 1'b0;
`endif
                end else begin
                    acc_d = total;
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef SIMD_DP_SAT_EN
                    sat_d = sat_q | ovf;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_mode_q   <= 2'b00;
            s1_prod_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_sum_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
`ifdef SIMD_DP_SAT_EN
            sat_q       <= 1'b0;
            out_sat_q   <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_mode_q   <= s1_mode_d;
            s1_prod_q   <= s1_prod_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_sum_q    <= s2_sum_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
`ifdef SIMD_DP_SAT_EN
            sat_q       <= sat_d;
            out_sat_q   <= out_sat_d;
`endif
        end
    end
endmodule
